key_debounce_load: RTL
======================

// Module: key_debounce_load
// PURPOSE
//  Upstream input-conditioning stage for the 3-bit D register. Synchronises a raw
//  active-low pushbutton and the data switches into the Clock domain, debounces the
//  button, and emits a one-cycle Load strobe with a stable D_out word. The register
//  then loads on a clean, clocked enable instead of being clocked directly by a
//  bouncing key.
// PARAMETERS
//  DATA_WIDTH       3       width of switch data path (SW_in / D_out)
//  SYNC_STAGES      2       flip-flops per synchroniser chain (>=2)
//  DEBOUNCE_CYCLES  500000  consecutive stable cycles needed to accept a key edge (>=2)
//  REPEAT_CYCLES    25000000 auto-repeat period in cycles (used only with AUTO_REPEAT_EN)
// PORTS
//  Clock    in   1           system clock, all state on rising edge
//  Resetn   in   1           asynchronous, active-low reset
//  KEY_n    in   1           raw pushbutton, 0 = pressed, asynchronous to Clock
//  SW_in    in   DATA_WIDTH  raw switch word, asynchronous to Clock
//  D_out    out  DATA_WIDTH  synchronised switch word captured at each Load
//  Load     out  1           one-cycle strobe: downstream register loads D_out
//  Pressed  out  1           debounced key level, 1 = pressed
// BEHAVIOUR
//  - Reset (Resetn=0, immediate): state=IDLE; all counters 0; Load=0; Pressed=0;
//    D_out=0; key sync chain =1 (released); switch sync chains =0.
//  - Sync: KEY_n and each SW_in bit pass through SYNC_STAGES flops; key_sync=~last flop.
//  - Debounce counter cnt, width $clog2(DEBOUNCE_CYCLES)+1, saturates at DEBOUNCE_CYCLES-1.
//  - FSM (registered, one state per edge):
//    IDLE:         key_sync=1 -> PRESS_WAIT, cnt=0.
//    PRESS_WAIT:   key_sync=0 -> IDLE, cnt=0 (bounce rejected, no Load).
//                  key_sync=1 & cnt<DEBOUNCE_CYCLES-1 -> cnt+1.
//                  key_sync=1 & cnt=DEBOUNCE_CYCLES-1 -> HELD; on this same edge
//                  Load<=1, D_out<=switch sync value, Pressed<=1.
//    HELD:         key_sync=0 -> RELEASE_WAIT, cnt=0.
//    RELEASE_WAIT: key_sync=1 -> HELD, no Load (release bounce rejected).
//                  key_sync=0 & cnt=DEBOUNCE_CYCLES-1 -> IDLE, Pressed<=0; else cnt+1.
//  - Load is high for exactly one cycle, then returns to 0. D_out changes only on
//    the edge that raises Load; it holds between strobes.
//  - Latency: KEY_n first sampled low at edge 0, held low -> Load high after
//    edge SYNC_STAGES+DEBOUNCE_CYCLES. Release -> Pressed low after edge
//    SYNC_STAGES+DEBOUNCE_CYCLES from first sampled high.
//  - Exactly one Load per accepted press; a press shorter than DEBOUNCE_CYCLES
//    synchronised cycles produces nothing.
//  - SW_in changes while HELD do not affect D_out (no auto-repeat build).
//  - Reset mid-operation: all state cleared at once. A key held through reset
//    release is treated as a new press: it is debounced and then gives one Load.
// CONFIGURATION
//  AUTO_REPEAT_EN defined: in HELD a repeat counter (cleared on every entry to
//    HELD) counts to REPEAT_CYCLES-1. On wrap it raises Load for one cycle,
//    recaptures D_out and restarts. Re-entry from RELEASE_WAIT restarts the count.
//  AUTO_REPEAT_EN undefined: no repeat counter is built; one Load per press only.
// TESTING  (DEBOUNCE_CYCLES=8, SYNC_STAGES=2, DATA_WIDTH=3, REPEAT_CYCLES=16)
//  1 Reset: Resetn=0 mid-cycle -> Load=0, Pressed=0, D_out=3'b000 immediately.
//  2 Clean press: SW_in=3'b101, KEY_n low from edge 0 -> Load=1 only after edge 10;
//    D_out=3'b101; Pressed=1; Load=0 after edge 11.
//  3 Bounce: KEY_n low 5 cycles, high 3, low steady -> exactly one Load, at 10
//    cycles after the start of the final low run.
//  4 Release bounce: while HELD, KEY_n high 4 cycles then low -> no Load,
//    Pressed stays 1; steady high -> Pressed=0 after 10 cycles.
//  5 Data hold: change SW_in to 3'b010 while HELD -> D_out stays 3'b101;
//    next press -> D_out=3'b010.
//  6 AUTO_REPEAT_EN: hold key 50 cycles after first Load -> further Loads every
//    16 cycles (3 extra); without macro -> 0 extra.

Source files
------------

// File: rtl/key_debounce_load.sv
// Key/switch synchroniser, pushbutton debouncer and one-cycle load strobe generator.
// Optional build macro AUTO_REPEAT_EN adds a periodic Load while the key is held.
module key_debounce_load #(
    parameter int DATA_WIDTH      = 3,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic                  Clock,
    input  logic                  Resetn,
    input  logic                  KEY_n,
    input  logic [DATA_WIDTH-1:0] SW_in,
    output logic [DATA_WIDTH-1:0] D_out,
    output logic                  Load,
    output logic                  Pressed
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
        $error("key_debounce_load: illegal parameter value");
    end

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] key_sync_q, key_sync_d;
    logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] sw_sync_q, sw_sync_d;
    logic                  load_q, load_d;
    logic                  pressed_q, pressed_d;
    logic [DATA_WIDTH-1:0] d_out_q, d_out_d;
    logic                  key_sync;
    logic [DATA_WIDTH-1:0] sw_sync;

`ifdef AUTO_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES) + 1;
    localparam logic [RW-1:0] RPT_MAX = RW'(REPEAT_CYCLES - 1);
    logic [RW-1:0] rpt_q, rpt_d;
`endif

    // Key chain resets to 1 so the button reads as released after reset.
    always_comb begin
        key_sync_d = {key_sync_q[SYNC_STAGES-2:0], KEY_n};
        sw_sync_d  = {sw_sync_q[SYNC_STAGES-2:0], SW_in};
        key_sync   = ~key_sync_q[SYNC_STAGES-1];
        sw_sync    = sw_sync_q[SYNC_STAGES-1];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        load_d    = 1'b0;
        pressed_d = pressed_q;
        d_out_d   = d_out_q;
`ifdef AUTO_REPEAT_EN
        rpt_d     = rpt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (key_sync) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!key_sync) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d   = HELD;
                    load_d    = 1'b1;
                    d_out_d   = sw_sync;
                    pressed_d = 1'b1;
`ifdef AUTO_REPEAT_EN
                    rpt_d     = '0;
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HELD: begin
                if (!key_sync) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
`ifdef AUTO_REPEAT_EN
                else if (rpt_q == RPT_MAX) begin
                    rpt_d   = '0;
                    load_d  = 1'b1;
                    d_out_d = sw_sync;
                end else begin
                    rpt_d = rpt_q + RW'(1);
                end
`endif
            end
            RELEASE_WAIT: begin
                // A short high blip is release bounce: back to HELD, no new Load.
                if (key_sync) begin
                    state_d = HELD;
`ifdef AUTO_REPEAT_EN
                    rpt_d   = '0;
`endif
                end else if (cnt_q == CNT_MAX) begin
                    state_d   = IDLE;
                    pressed_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            key_sync_q <= '1;
            sw_sync_q  <= '0;
            load_q     <= 1'b0;
            pressed_q  <= 1'b0;
            d_out_q    <= '0;
`ifdef AUTO_REPEAT_EN
            rpt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            key_sync_q <= key_sync_d;
            sw_sync_q  <= sw_sync_d;
            load_q     <= load_d;
            pressed_q  <= pressed_d;
            d_out_q    <= d_out_d;
`ifdef AUTO_REPEAT_EN
            rpt_q      <= rpt_d;
`endif
        end
    end

    assign D_out   = d_out_q;
    assign Load    = load_q;
    assign Pressed = pressed_q;

endmodule
